// File: rtl/ikbd_tx_pkt_arb.sv
// Round-robin packet arbiter: keyboard, mouse and joystick report generators share one SCI transmit path.
// A requester owns the transmitter for a whole packet, bounded by MAXLEN bytes and a stall timeout.
module ikbd_tx_pkt_arb #(
    parameter int MAXLEN  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst_n,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    input  logic        tx_empty,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        err_len,
    output logic        err_tmo
);

    localparam logic [3:0] MAXL = 4'(MAXLEN);
    localparam logic [7:0] TMO  = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [2:0]  grant_q, grant_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        hold_q, hold_d;
    logic        last_q, last_d;
    logic        tx_load_q, tx_load_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        err_len_q, err_len_d;
    logic        err_tmo_q, err_tmo_d;

    logic [1:0]  pick;
    logic [1:0]  rr_next;
    logic [7:0]  sel_data;
    logic        sel_valid;
    logic        sel_last;
    logic        xfer;

    // First requester at or after the rr pointer, wrapping mod 3.
    always_comb begin
        pick = 2'd0;
        case (rr_q)
            2'd1:    pick = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            2'd2:    pick = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: pick = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_data = 8'h00;
        case (gidx_q)
            2'd1:    sel_data = req_data[15:8];
            2'd2:    sel_data = req_data[23:16];
            default: sel_data = req_data[7:0];
        endcase
    end

    assign sel_valid = |(req_valid & grant_q);
    assign sel_last  = |(req_last & grant_q);
    assign rr_next   = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
    assign req_ready = (state_q == SEND) ? (grant_q & {3{tx_empty}}) : 3'b000;
    assign xfer      = (state_q == SEND) && tx_empty && sel_valid;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        byte_cnt_d  = byte_cnt_q;
        stall_cnt_d = stall_cnt_q;
        hold_d      = hold_q;
        last_d      = last_q;
        tx_load_d   = 1'b0;
        tx_data_d   = tx_data_q;
        err_len_d   = 1'b0;
        err_tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gidx_d      = pick;
                    grant_d     = 3'b001 << pick;
                    byte_cnt_d  = 4'd0;
                    stall_cnt_d = 8'd0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_load_d   = 1'b1;
                    tx_data_d   = sel_data;
                    last_d      = sel_last;
                    byte_cnt_d  = (byte_cnt_q == 4'hF) ? byte_cnt_q : byte_cnt_q + 4'd1;
                    stall_cnt_d = 8'd0;
                    hold_d      = 1'b0;
                    state_d     = HOLD;
                end else if (tx_empty) begin
                    stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
                    if (stall_cnt_d >= TMO) begin
                        err_tmo_d = 1'b1;
                        grant_d   = 3'b000;
                        rr_d      = rr_next;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                // Two dead cycles let the transmitter drop tx_empty after a load.
                if (!hold_q) begin
                    hold_d = 1'b1;
                end else if (last_q || byte_cnt_q == MAXL) begin
                    err_len_d = !last_q;
                    grant_d   = 3'b000;
                    rr_d      = rr_next;
                    state_d   = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 2'd0;
            gidx_q      <= 2'd0;
            grant_q     <= 3'b000;
            byte_cnt_q  <= 4'd0;
            stall_cnt_q <= 8'd0;
            hold_q      <= 1'b0;
            last_q      <= 1'b0;
            tx_load_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            tx_load_q   <= tx_load_d;
            tx_data_q   <= tx_data_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign tx_load = tx_load_q;
    assign tx_data = tx_data_q;
    assign err_len = err_len_q;
    assign err_tmo = err_tmo_q;

endmodule
